thread_scheduler: RTL and testbench
===================================

# thread_scheduler

Per-cycle issue scheduler for the multithreaded pipeline. Each cycle it selects the thread whose PC is fetched by stage_if (`scheduler_thread`) by round-robin over threads that are not stalled on a memory miss and not finished. It also owns the single-master exception state: it accepts an exception from writeback, drains the pipeline, and restricts issue to the master thread until that thread's IRET commits.

## Interface
Parameters:
- `N_THREADS`, default `common::n_threads` (8): number of hardware threads.
- `DRAIN_CYCLES`, default 7: issue-free cycles after accepting an exception (IF + ID + 4×EX + TL depth).

Ports (`TID_W = $clog2(N_THREADS)`):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stalled`  in  N_THREADS  per-thread miss stall mask (bit i = thread i).
- `halted`  in  N_THREADS  per-thread finished mask (waiting PC reached end PC).
- `exc_req`  in  1  writeback detected an exception this cycle.
- `exc_req_thread`  in  TID_W  thread raising `exc_req`.
- `iret_en`  in  1  an IRET committed in writeback this cycle.
- `iret_thread`  in  TID_W  thread committing the IRET.
- `sched_valid`  out  1  `sched_thread` is a legal issue this cycle.
- `sched_thread`  out  TID_W  thread selected for fetch (drives `scheduler_thread`).
- `exc_state_en`  out  1  exception state active (DRAIN or EXC).
- `exc_master`  out  TID_W  thread owning the exception state.
- `exc_en`  out  1  one-cycle pulse when an exception is accepted.
- `exc_thread`  out  TID_W  accepted thread, valid while `exc_en` is high.

## Operation
- Eligibility mask `elig = ~stalled & ~halted & mask`.
  - `mask` = all ones in IDLE, all zeros in DRAIN, onehot(`exc_master`) in EXC.
- Round-robin pointer `last` holds the last granted thread. The search starts at `last+1` and wraps at N_THREADS-1 → 0. The first eligible thread wins.
- When a grant is made, `last` updates to the granted thread. When nothing is eligible, `last` holds and `sched_valid`=0; `sched_thread` keeps its previous value.
- FSM states:
  - IDLE → DRAIN on `exc_req`. Latch `exc_master`=`exc_req_thread`, pulse `exc_en`/`exc_thread`, load drain counter with DRAIN_CYCLES-1.
  - DRAIN: the counter decrements each cycle. At 0, go to EXC.
  - EXC → IDLE on `iret_en` with `iret_thread`==`exc_master`.
  - `iret_en` from any other thread is ignored in all states.
- Dropped exception requests (writeback's exception fence replays them):
  - `exc_req` in DRAIN or EXC, from any thread including the master.
  - `exc_req` in the same cycle as a matching IRET in EXC.
- A master that is stalled or halted in EXC yields `sched_valid`=0. No other thread may issue.
- `exc_master` holds its value after return to IDLE until the next accepted exception.

## Timing
- Registered outputs: `elig` and FSM inputs sampled in cycle t drive `sched_valid`/`sched_thread` in t+1.
- `exc_en` asserts in the cycle after `exc_req`. `exc_state_en` rises in that same cycle.
- DRAIN lasts exactly DRAIN_CYCLES cycles with `sched_valid`=0. The first master issue can occur in the next cycle.
- `exc_state_en` falls in the cycle after the matching `iret_en`. Normal round-robin resumes from `last` in that cycle.
- Reset values:
  - `sched_valid`=0, `sched_thread`=0.
  - `last`=N_THREADS-1, so the first grant goes to thread 0.
  - FSM=IDLE, counter=0.
  - `exc_state_en`=0, `exc_master`=0, `exc_en`=0, `exc_thread`=0.
- Reset asserted mid-DRAIN or mid-EXC returns to IDLE next cycle; no `exc_en` pulse is emitted.
- Throughput: one grant per cycle when any thread is eligible.

## Structure
- `common` package additions:
  - `typedef enum logic [1:0] {IDLE, DRAIN, EXC} sched_state_t`.
  - `threadid_t` is reused for all thread-id ports.
- Sub-module `rr_picker`: combinational. Inputs are the eligibility vector and start index. Outputs are `found` and `winner`. Implement as a doubled-vector priority search.
- The counter, FSM and output registers live in `thread_scheduler`.

## Test plan
- All threads eligible, 10 cycles after reset → `sched_thread` 0,1,…,7,0,1 with `sched_valid`=1 throughout.
- `stalled`=8'b0000_0110 after grant 0 → next grants 3,4,5,6,7,0 (1 and 2 skipped). Clearing bit 1 makes 1 win after 0.
- `stalled|halted`=8'hFF for 3 cycles → `sched_valid`=0 for 3 cycles with `last` held. Releasing thread 5 → grant 5.
- `exc_req` thread 3 in IDLE:
  - `exc_en` pulses with `exc_thread`=3.
  - 7 cycles of `sched_valid`=0.
  - Then only thread 3 issues.
  - `iret_en` from thread 2 is ignored; `iret_en` from thread 3 → IDLE next cycle.
- `exc_req` thread 6 during EXC of master 3, and again simultaneously with the matching IRET → both dropped, no `exc_en`, `exc_master` stays 3.
- `rst` asserted during DRAIN → next cycle IDLE, `exc_state_en`=0, first grant is thread 0.

Source files
------------

// File: rtl/thread_scheduler_pkg.sv
// Shared types for the multithreaded issue scheduler.
// Thread ids, thread count and the exception FSM encoding.
package thread_scheduler_pkg;

    localparam int n_threads = 8;

    typedef logic [$clog2(n_threads)-1:0] threadid_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        EXC
    } sched_state_t;

endpackage

// File: rtl/thread_scheduler_if.sv
// Pipeline <-> scheduler bundle: stall/halt masks, exception
// and IRET events in; issue selection and exception state out.
interface thread_scheduler_if
    import thread_scheduler_pkg::*;
#(
    parameter int N_THREADS = n_threads
) ();

    localparam int TID_W = $clog2(N_THREADS);

    logic [N_THREADS-1:0] stalled;
    logic [N_THREADS-1:0] halted;
    logic                 exc_req;
    logic [TID_W-1:0]     exc_req_thread;
    logic                 iret_en;
    logic [TID_W-1:0]     iret_thread;

    logic                 sched_valid;
    logic [TID_W-1:0]     sched_thread;
    logic                 exc_state_en;
    logic [TID_W-1:0]     exc_master;
    logic                 exc_en;
    logic [TID_W-1:0]     exc_thread;

    modport master (
        output stalled,
        output halted,
        output exc_req,
        output exc_req_thread,
        output iret_en,
        output iret_thread,
        input  sched_valid,
        input  sched_thread,
        input  exc_state_en,
        input  exc_master,
        input  exc_en,
        input  exc_thread
    );

    modport slave (
        input  stalled,
        input  halted,
        input  exc_req,
        input  exc_req_thread,
        input  iret_en,
        input  iret_thread,
        output sched_valid,
        output sched_thread,
        output exc_state_en,
        output exc_master,
        output exc_en,
        output exc_thread
    );

endinterface

// File: rtl/thread_scheduler_rr_picker.sv
// Round-robin picker: first set bit of elig at or after start,
// wrapping past N-1 to 0, found via a doubled-vector search.
module rr_picker
    import thread_scheduler_pkg::*;
#(
    parameter int N     = n_threads,
    parameter int TID_W = $clog2(N)
) (
    input  logic [N-1:0]     elig_i,
    input  logic [TID_W-1:0] start_i,
    output logic             found_o,
    output logic [TID_W-1:0] winner_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] rot;
    logic [TID_W:0] sum;

    assign dbl = {elig_i, elig_i};
    assign rot = dbl >> start_i;

    // Scan high to low so the lowest offset from start wins.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        sum      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_o = 1'b1;
                sum = {1'b0, start_i} + (TID_W+1)'(i);
                if (sum >= (TID_W+1)'(N))
                    winner_o = TID_W'(sum - (TID_W+1)'(N));
                else
                    winner_o = TID_W'(sum);
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Per-cycle round-robin thread issue plus the single-master
// exception state (accept, drain, master-only until IRET).
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter int N_THREADS    = n_threads,
    parameter int DRAIN_CYCLES = 7
) (
    input  logic               clk,
    input  logic               rst,
    thread_scheduler_if.slave  bus
);

    localparam int TID_W = $clog2(N_THREADS);
    localparam int CNT_W =
        (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    sched_state_t         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TID_W-1:0]     last_q;
    logic [TID_W-1:0]     master_q;
    logic [TID_W-1:0]     sched_thread_q;
    logic [TID_W-1:0]     exc_thread_q;
    logic                 sched_valid_q;
    logic                 exc_en_q;

    logic                 accept;
    logic                 iret_match;
    logic [N_THREADS-1:0] mask;
    logic [N_THREADS-1:0] elig;
    logic [TID_W-1:0]     start;
    logic                 found;
    logic [TID_W-1:0]     winner;

    rr_picker #(
        .N     (N_THREADS),
        .TID_W (TID_W)
    ) u_pick (
        .elig_i   (elig),
        .start_i  (start),
        .found_o  (found),
        .winner_o (winner)
    );

    // State, drain counter, round-robin pointer and output regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            last_q         <= TID_W'(N_THREADS - 1);
            master_q       <= '0;
            sched_valid_q  <= 1'b0;
            sched_thread_q <= '0;
            exc_en_q       <= 1'b0;
            exc_thread_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sched_valid_q <= found;
            exc_en_q      <= accept;
            if (found) begin
                sched_thread_q <= winner;
                last_q         <= winner;
            end
            if (accept) begin
                master_q     <= bus.exc_req_thread;
                exc_thread_q <= bus.exc_req_thread;
            end
        end
    end

    // Next state: requests only land in IDLE; only the master's
    // IRET leaves EXC.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        iret_match = bus.iret_en &&
                     (bus.iret_thread == master_q);
        unique case (state_q)
            IDLE: begin
                if (bus.exc_req) begin
                    accept  = 1'b1;
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0)
                    state_d = EXC;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            EXC: begin
                if (iret_match)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue mask follows the state the registered grant lands in,
    // so every DRAIN cycle shows no issue and EXC issues at once.
    always_comb begin
        mask = '0;
        unique case (state_d)
            IDLE:    mask = '1;
            DRAIN:   mask = '0;
            EXC:     mask = N_THREADS'(1) << master_q;
            default: mask = '0;
        endcase
        elig = ~bus.stalled & ~bus.halted & mask;
        if (last_q == TID_W'(N_THREADS - 1))
            start = '0;
        else
            start = last_q + TID_W'(1);
    end

    assign bus.sched_valid  = sched_valid_q;
    assign bus.sched_thread = sched_thread_q;
    assign bus.exc_state_en = (state_q != IDLE);
    assign bus.exc_master   = master_q;
    assign bus.exc_en       = exc_en_q;
    assign bus.exc_thread   = exc_thread_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: issue expectations
// go to a scoreboard queue and are compared on the falling edge.
module tb_thread_scheduler;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc_cnt;

    typedef struct packed {
        int         cyc;
        logic       v;
        logic [2:0] t;
    } exp_t;

    exp_t sb[$];

    thread_scheduler_if #(.N_THREADS(8)) bus ();

    thread_scheduler #(
        .N_THREADS    (8),
        .DRAIN_CYCLES (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            exp_t e;
            e = sb.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc_cnt) begin
                errors = errors + 1;
                $display("FAIL sb_late: due %0d now %0d",
                         e.cyc, cyc_cnt);
            end else if (bus.sched_valid !== e.v ||
                         bus.sched_thread !== e.t) begin
                errors = errors + 1;
                $display("FAIL issue@%0d: got v=%0b t=%0d want v=%0b t=%0d",
                         cyc_cnt, bus.sched_valid, bus.sched_thread,
                         e.v, e.t);
            end
        end
    end

    // Queue the expected issue for the next edge, then take it.
    task automatic cyc(input bit v, input int t);
        exp_t e;
        e.cyc = cyc_cnt + 1;
        e.v   = v;
        e.t   = 3'(t);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stalled        = '0;
        bus.halted         = '0;
        bus.exc_req        = 1'b0;
        bus.exc_req_thread = '0;
        bus.iret_en        = 1'b0;
        bus.iret_thread    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        checks = checks + 1;
        if (bus.sched_valid !== 1'b0 || bus.sched_thread !== 3'd0) begin
            errors = errors + 1;
            $display("FAIL reset_sched: got v=%0b t=%0d want 0 0",
                     bus.sched_valid, bus.sched_thread);
        end
        checks = checks + 1;
        if (bus.exc_state_en !== 1'b0 || bus.exc_master !== 3'd0) begin
            errors = errors + 1;
            $display("FAIL reset_exc_state: got %0b %0d want 0 0",
                     bus.exc_state_en, bus.exc_master);
        end
        checks = checks + 1;
        if (bus.exc_en !== 1'b0 || bus.exc_thread !== 3'd0) begin
            errors = errors + 1;
            $display("FAIL reset_exc_en: got %0b %0d want 0 0",
                     bus.exc_en, bus.exc_thread);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 10; i++)
            cyc(1'b1, i % 8);
    endtask

    task automatic test_stall();
        do_reset();
        cyc(1'b1, 0);
        bus.stalled = 8'b0000_0110;
        cyc(1'b1, 3);
        cyc(1'b1, 4);
        cyc(1'b1, 5);
        cyc(1'b1, 6);
        cyc(1'b1, 7);
        cyc(1'b1, 0);
        bus.stalled = 8'b0000_0100;
        cyc(1'b1, 1);
        cyc(1'b1, 3);
    endtask

    task automatic test_all_blocked();
        bus.stalled = 8'hF0;
        bus.halted  = 8'h0F;
        cyc(1'b0, 3);
        cyc(1'b0, 3);
        cyc(1'b0, 3);
        bus.stalled = 8'hDF;
        bus.halted  = 8'h00;
        cyc(1'b1, 5);
        clear_inputs();
    endtask

    task automatic test_exception();
        do_reset();
        bus.exc_req        = 1'b1;
        bus.exc_req_thread = 3'd3;
        cyc(1'b0, 0);
        bus.exc_req = 1'b0;
        checks = checks + 1;
        if (bus.exc_en !== 1'b1 || bus.exc_thread !== 3'd3 ||
            bus.exc_state_en !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL exc_accept: en=%0b thr=%0d st=%0b want 1 3 1",
                     bus.exc_en, bus.exc_thread, bus.exc_state_en);
        end
        cyc(1'b0, 0);
        checks = checks + 1;
        if (bus.exc_en !== 1'b0 || bus.exc_master !== 3'd3) begin
            errors = errors + 1;
            $display("FAIL exc_pulse: en=%0b mst=%0d want 0 3",
                     bus.exc_en, bus.exc_master);
        end
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 0);
        cyc(1'b1, 3);
        cyc(1'b1, 3);
        bus.iret_en     = 1'b1;
        bus.iret_thread = 3'd2;
        cyc(1'b1, 3);
        checks = checks + 1;
        if (bus.exc_state_en !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL iret_other: exc_state_en=%0b want 1",
                     bus.exc_state_en);
        end
        bus.iret_thread = 3'd3;
        cyc(1'b1, 4);
        bus.iret_en = 1'b0;
        checks = checks + 1;
        if (bus.exc_state_en !== 1'b0 || bus.exc_master !== 3'd3) begin
            errors = errors + 1;
            $display("FAIL iret_master: st=%0b mst=%0d want 0 3",
                     bus.exc_state_en, bus.exc_master);
        end
        cyc(1'b1, 5);
    endtask

    task automatic test_drop();
        do_reset();
        bus.exc_req        = 1'b1;
        bus.exc_req_thread = 3'd3;
        cyc(1'b0, 0);
        bus.exc_req = 1'b0;
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 0);
        cyc(1'b1, 3);
        bus.exc_req        = 1'b1;
        bus.exc_req_thread = 3'd6;
        cyc(1'b1, 3);
        bus.exc_req = 1'b0;
        checks = checks + 1;
        if (bus.exc_en !== 1'b0 || bus.exc_master !== 3'd3) begin
            errors = errors + 1;
            $display("FAIL drop_in_exc: en=%0b mst=%0d want 0 3",
                     bus.exc_en, bus.exc_master);
        end
        bus.stalled = 8'h08;
        cyc(1'b0, 3);
        bus.stalled        = 8'h00;
        bus.exc_req        = 1'b1;
        bus.exc_req_thread = 3'd6;
        bus.iret_en        = 1'b1;
        bus.iret_thread    = 3'd3;
        cyc(1'b1, 4);
        clear_inputs();
        checks = checks + 1;
        if (bus.exc_en !== 1'b0 || bus.exc_state_en !== 1'b0 ||
            bus.exc_master !== 3'd3) begin
            errors = errors + 1;
            $display("FAIL drop_with_iret: en=%0b st=%0b mst=%0d want 0 0 3",
                     bus.exc_en, bus.exc_state_en, bus.exc_master);
        end
        cyc(1'b1, 5);
        checks = checks + 1;
        if (bus.exc_en !== 1'b0 || bus.exc_state_en !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL drop_late: en=%0b st=%0b want 0 0",
                     bus.exc_en, bus.exc_state_en);
        end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        bus.exc_req        = 1'b1;
        bus.exc_req_thread = 3'd3;
        cyc(1'b0, 0);
        bus.exc_req = 1'b0;
        cyc(1'b0, 0);
        cyc(1'b0, 0);
        rst = 1'b1;
        cyc(1'b0, 0);
        rst = 1'b0;
        checks = checks + 1;
        if (bus.exc_state_en !== 1'b0 || bus.exc_en !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL rst_drain: st=%0b en=%0b want 0 0",
                     bus.exc_state_en, bus.exc_en);
        end
        cyc(1'b1, 0);
        checks = checks + 1;
        if (bus.exc_state_en !== 1'b0 || bus.exc_en !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL rst_drain_after: st=%0b en=%0b want 0 0",
                     bus.exc_state_en, bus.exc_en);
        end
        cyc(1'b1, 1);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc_cnt = 0;
        rst     = 1'b1;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_stall();
        test_all_blocked();
        test_exception();
        test_drop();
        test_reset_in_drain();
        @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sb_drain: %0d left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
